// File: rtl/apu_reg_decoder.sv
// Sound unit CPU-side register file: decodes 0xFF10-0xFF3F byte accesses,
// holds NR10-NR52 and wave RAM, and emits trigger / length-load strobes.
module apu_reg_decoder #(
  parameter logic [127:0] WAVE_INIT = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   addr,
  input  logic         wr_en,
  input  logic [7:0]   wr_data,
  input  logic         rd_en,
  output logic [7:0]   rd_data,
  output logic         rd_valid,
  input  logic [3:0]   ch_active,
  output logic [39:0]  nr1x,
  output logic [31:0]  nr2x,
  output logic [39:0]  nr3x,
  output logic [31:0]  nr4x,
  output logic [15:0]  nr5x,
  output logic         apu_on,
  output logic [3:0]   trig,
  output logic [3:0]   len_load,
  output logic [127:0] wave_table
);

  // Slot i holds register at address 0x10+i; slots 5 (0x15) and 15 (0x1F) are holes.
  localparam int unsigned NREG = 22;

  logic [NREG-1:0][7:0] regs_q, regs_d;
  logic                 apu_on_q, apu_on_d;
  logic [127:0]         wave_q, wave_d;
  logic [3:0]           trig_q, trig_d;
  logic [3:0]           len_q, len_d;
  logic [7:0]           rd_data_q, rd_data_d;
  logic                 rd_valid_q, rd_valid_d;
  logic [7:0]           rd_val;

  function automatic logic is_mapped(input int unsigned i);
    return (i != 5) && (i != 15);
  endfunction

  // Trigger bit 7 of NRx4 is write-only and never stored.
  function automatic logic [7:0] store_mask(input int unsigned i);
    return (i == 4 || i == 9 || i == 14 || i == 19) ? 8'h7F : 8'hFF;
  endfunction

  // Bits that always read back as 1 (unused or write-only fields).
  function automatic logic [7:0] read_mask(input int unsigned i);
    case (i)
      0:       return 8'h80;
      1, 6:    return 8'h3F;
      3, 8:    return 8'hFF;
      4, 9:    return 8'hBF;
      10:      return 8'h7F;
      11, 13:  return 8'hFF;
      12:      return 8'h9F;
      14, 19:  return 8'hBF;
      16:      return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction

  // Read mux over the pre-write state; anything unmapped returns FF.
  always_comb begin
    rd_val = 8'hFF;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (addr == 8'(i + 16) && is_mapped(i)) rd_val = regs_q[5'(i)] | read_mask(i);
    end
    if (addr == 8'h26) rd_val = {apu_on_q, 3'b111, ch_active};
    // Byte 0x30+i packs sample 2i in the high nibble, sample 2i+1 in the low nibble.
    if (addr[7:4] == 4'h3)
      rd_val = {wave_q[{addr[3:0], 3'b000} +: 4], wave_q[{addr[3:0], 3'b100} +: 4]};
  end

  // Write decode, power-off clear, strobe generation and read capture.
  always_comb begin
    regs_d     = regs_q;
    apu_on_d   = apu_on_q;
    wave_d     = wave_q;
    trig_d     = '0;
    len_d      = '0;
    rd_valid_d = rd_en;
    rd_data_d  = rd_en ? rd_val : rd_data_q;
    if (wr_en) begin
      if (apu_on_q) begin
        for (int unsigned i = 0; i < NREG; i++) begin
          if (addr == 8'(i + 16) && is_mapped(i)) begin
            regs_d[5'(i)] = wr_data & store_mask(i);
            case (i)
              4:       trig_d[0] = wr_data[7];
              9:       trig_d[1] = wr_data[7];
              14:      trig_d[2] = wr_data[7];
              19:      trig_d[3] = wr_data[7];
              1:       len_d[0]  = 1'b1;
              6:       len_d[1]  = 1'b1;
              11:      len_d[2]  = 1'b1;
              16:      len_d[3]  = 1'b1;
              default: ;
            endcase
          end
        end
      end
      if (addr == 8'h26) begin
        apu_on_d = wr_data[7];
        if (apu_on_q && !wr_data[7]) regs_d = '0;
      end
      if (addr[7:4] == 4'h3)
        wave_d[{addr[3:0], 3'b000} +: 8] = {wr_data[3:0], wr_data[7:4]};
    end
  end

  // State and strobe registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q     <= '0;
      apu_on_q   <= 1'b0;
      wave_q     <= WAVE_INIT;
      trig_q     <= '0;
      len_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      apu_on_q   <= apu_on_d;
      wave_q     <= wave_d;
      trig_q     <= trig_d;
      len_q      <= len_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  assign nr1x       = regs_q[4:0];
  assign nr2x       = regs_q[9:6];
  assign nr3x       = regs_q[14:10];
  assign nr4x       = regs_q[19:16];
  assign nr5x       = regs_q[21:20];
  assign apu_on     = apu_on_q;
  assign trig       = trig_q;
  assign len_load   = len_q;
  assign wave_table = wave_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_apu_reg_decoder.sv
// Testbench for apu_reg_decoder: directed scenarios plus randomized traffic
// checked against a byte-addressed behavioural model of the register map.
module tb_apu_reg_decoder;

  localparam logic [127:0] INIT = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   addr;
  logic         wr_en;
  logic [7:0]   wr_data;
  logic         rd_en;
  logic [7:0]   rd_data;
  logic         rd_valid;
  logic [3:0]   ch_active;
  logic [39:0]  nr1x;
  logic [31:0]  nr2x;
  logic [39:0]  nr3x;
  logic [31:0]  nr4x;
  logic [15:0]  nr5x;
  logic         apu_on;
  logic [3:0]   trig;
  logic [3:0]   len_load;
  logic [127:0] wave_table;

  int checks = 0;
  int errors = 0;

  apu_reg_decoder #(.WAVE_INIT(INIT)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .ch_active(ch_active),
    .nr1x(nr1x), .nr2x(nr2x), .nr3x(nr3x), .nr4x(nr4x), .nr5x(nr5x),
    .apu_on(apu_on), .trig(trig), .len_load(len_load), .wave_table(wave_table)
  );

  always #5 clk = ~clk;

  // Behavioural model: memory indexed by CPU address, wave RAM as 32 samples.
  logic [7:0] m_reg [0:255];
  logic       m_on;
  logic [3:0] m_wave [0:31];
  logic [7:0] exp_rd_data;
  logic       exp_rd_valid;
  logic [3:0] exp_trig;
  logic [3:0] exp_len;

  function automatic logic m_mapped(input logic [7:0] a);
    return a >= 8'h10 && a <= 8'h25 && a != 8'h15 && a != 8'h1F;
  endfunction

  function automatic logic [7:0] m_mask(input logic [7:0] a);
    case (a)
      8'h10: return 8'h80;  8'h11: return 8'h3F;  8'h13: return 8'hFF;
      8'h14: return 8'hBF;  8'h16: return 8'h3F;  8'h18: return 8'hFF;
      8'h19: return 8'hBF;  8'h1A: return 8'h7F;  8'h1B: return 8'hFF;
      8'h1C: return 8'h9F;  8'h1D: return 8'hFF;  8'h1E: return 8'hBF;
      8'h20: return 8'hFF;  8'h23: return 8'hBF;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int k;
    if (a == 8'h26) return {m_on, 3'b111, ch_active};
    if (a >= 8'h30 && a <= 8'h3F) begin
      k = 2 * int'(a - 8'h30);
      return {m_wave[k], m_wave[k+1]};
    end
    if (m_mapped(a)) return m_reg[a] | m_mask(a);
    return 8'hFF;
  endfunction

  function automatic logic [127:0] m_wave_img();
    logic [127:0] w;
    for (int k = 0; k < 32; k++) w[4*k +: 4] = m_wave[k];
    return w;
  endfunction

  task automatic model_reset();
    for (int a = 0; a < 256; a++) m_reg[a] = 8'h00;
    for (int k = 0; k < 32; k++) m_wave[k] = INIT[4*k +: 4];
    m_on = 1'b0;
    exp_rd_data = 8'h00; exp_rd_valid = 1'b0; exp_trig = 4'h0; exp_len = 4'h0;
  endtask

  task automatic model_step(input logic [7:0] a, input logic we, input logic [7:0] d,
                            input logic re);
    int k;
    exp_rd_valid = re;
    if (re) exp_rd_data = m_read(a);
    exp_trig = 4'h0;
    exp_len  = 4'h0;
    if (we) begin
      if (m_on && m_mapped(a)) begin
        case (a)
          8'h14: begin m_reg[a] = d & 8'h7F; exp_trig[0] = d[7]; end
          8'h19: begin m_reg[a] = d & 8'h7F; exp_trig[1] = d[7]; end
          8'h1E: begin m_reg[a] = d & 8'h7F; exp_trig[2] = d[7]; end
          8'h23: begin m_reg[a] = d & 8'h7F; exp_trig[3] = d[7]; end
          8'h11: begin m_reg[a] = d; exp_len[0] = 1'b1; end
          8'h16: begin m_reg[a] = d; exp_len[1] = 1'b1; end
          8'h1B: begin m_reg[a] = d; exp_len[2] = 1'b1; end
          8'h20: begin m_reg[a] = d; exp_len[3] = 1'b1; end
          default: m_reg[a] = d;
        endcase
      end
      if (a == 8'h26) begin
        if (m_on && !d[7]) for (int r = 8'h10; r <= 8'h25; r++) m_reg[r] = 8'h00;
        m_on = d[7];
      end
      if (a >= 8'h30 && a <= 8'h3F) begin
        k = 2 * int'(a - 8'h30);
        m_wave[k]   = d[7:4];
        m_wave[k+1] = d[3:0];
      end
    end
  endtask

  // Drive one cycle of stimulus, keep the model in step, sample #1 after the edge.
  task automatic do_cycle(input logic [7:0] a, input logic we, input logic [7:0] d,
                          input logic re);
    addr = a; wr_en = we; wr_data = d; rd_en = re;
    model_step(a, we, d, re);
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    addr = 8'h00; wr_en = 1'b0; wr_data = 8'h00; rd_en = 1'b0; ch_active = 4'h0;
    rst_n = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({nr1x, nr2x, nr3x, nr4x, nr5x, apu_on, trig, len_load, rd_data, rd_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs nr1x=%h nr5x=%h apu_on=%b trig=%b len=%b rd=%h v=%b expected all 0",
               nr1x, nr5x, apu_on, trig, len_load, rd_data, rd_valid);
    end
    checks++;
    if (wave_table !== INIT) begin
      errors++; $display("FAIL reset_wave got %h expected %h", wave_table, INIT);
    end
    @(negedge clk); rst_n = 1'b1;
    do_cycle(8'h10, 1'b0, 8'h00, 1'b1);
    checks++;
    if (rd_data !== 8'h80 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL reset_read_nr10 got %h/%b expected 80/1", rd_data, rd_valid);
    end
    do_cycle(8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (rd_data !== 8'h80 || rd_valid !== 1'b0) begin
      errors++; $display("FAIL read_hold got %h/%b expected 80/0", rd_data, rd_valid);
    end
  endtask

  task automatic test_trigger();
    do_cycle(8'h26, 1'b1, 8'h80, 1'b0);
    checks++;
    if (apu_on !== 1'b1) begin errors++; $display("FAIL power_on got %b expected 1", apu_on); end
    do_cycle(8'h14, 1'b1, 8'hC7, 1'b0);
    checks++;
    if (trig !== 4'b0001 || nr1x[39:32] !== 8'h47) begin
      errors++; $display("FAIL trig_nr14 trig=%b nr14=%h expected 0001/47", trig, nr1x[39:32]);
    end
    do_cycle(8'h14, 1'b0, 8'h00, 1'b1);
    checks++;
    if (trig !== 4'b0000 || rd_data !== 8'hFF) begin
      errors++; $display("FAIL trig_single trig=%b rd=%h expected 0000/FF", trig, rd_data);
    end
    do_cycle(8'h19, 1'b1, 8'h80, 1'b0);
    checks++;
    if (trig !== 4'b0010) begin errors++; $display("FAIL b2b_first got %b expected 0010", trig); end
    do_cycle(8'h19, 1'b1, 8'h80, 1'b0);
    checks++;
    if (trig !== 4'b0010) begin errors++; $display("FAIL b2b_second got %b expected 0010", trig); end
    do_cycle(8'h1E, 1'b1, 8'hFF, 1'b0);
    checks++;
    if (trig !== 4'b0100 || nr3x[39:32] !== 8'h7F) begin
      errors++; $display("FAIL trig_nr34 trig=%b nr34=%h expected 0100/7F", trig, nr3x[39:32]);
    end
    do_cycle(8'h23, 1'b1, 8'h80, 1'b0);
    checks++;
    if (trig !== 4'b1000) begin errors++; $display("FAIL trig_nr44 got %b expected 1000", trig); end
    do_cycle(8'h23, 1'b1, 8'h7F, 1'b0);
    checks++;
    if (trig !== 4'b0000) begin errors++; $display("FAIL trig_bit7_clear got %b expected 0000", trig); end
  endtask

  task automatic test_len_load();
    do_cycle(8'h20, 1'b1, 8'h05, 1'b0);
    checks++;
    if (len_load !== 4'b1000 || nr4x[7:0] !== 8'h05) begin
      errors++; $display("FAIL len_nr41 len=%b nr41=%h expected 1000/05", len_load, nr4x[7:0]);
    end
    do_cycle(8'h16, 1'b1, 8'h00, 1'b0);
    checks++;
    if (len_load !== 4'b0010) begin errors++; $display("FAIL len_nr21 got %b expected 0010", len_load); end
    do_cycle(8'h00, 1'b0, 8'h00, 1'b0);
    checks++;
    if (len_load !== 4'b0000) begin errors++; $display("FAIL len_single got %b expected 0000", len_load); end
  endtask

  task automatic test_power_off();
    do_cycle(8'h12, 1'b1, 8'hF3, 1'b0);
    do_cycle(8'h24, 1'b1, 8'h77, 1'b0);
    checks++;
    if (nr1x[23:16] !== 8'hF3 || nr5x[7:0] !== 8'h77) begin
      errors++; $display("FAIL pre_off nr12=%h nr50=%h expected F3/77", nr1x[23:16], nr5x[7:0]);
    end
    do_cycle(8'h26, 1'b1, 8'h00, 1'b0);
    checks++;
    if ({nr1x, nr2x, nr3x, nr4x, nr5x} !== '0 || apu_on !== 1'b0) begin
      errors++; $display("FAIL power_off_clear nr1x=%h nr4x=%h apu_on=%b expected 0", nr1x, nr4x, apu_on);
    end
    do_cycle(8'h12, 1'b1, 8'hF3, 1'b0);
    checks++;
    if (nr1x !== 40'h0) begin errors++; $display("FAIL off_write_ignored nr1x=%h expected 0", nr1x); end
    do_cycle(8'h14, 1'b1, 8'h80, 1'b0);
    checks++;
    if (trig !== 4'h0) begin errors++; $display("FAIL off_no_trig got %b expected 0000", trig); end
    do_cycle(8'h11, 1'b1, 8'h00, 1'b0);
    checks++;
    if (len_load !== 4'h0) begin errors++; $display("FAIL off_no_len got %b expected 0000", len_load); end
    do_cycle(8'h30, 1'b1, 8'hAB, 1'b0);
    checks++;
    if (wave_table[7:0] !== 8'hBA) begin
      errors++; $display("FAIL off_wave_write got %h expected BA", wave_table[7:0]);
    end
    do_cycle(8'h30, 1'b0, 8'h00, 1'b1);
    checks++;
    if (rd_data !== 8'hAB) begin errors++; $display("FAIL wave_read got %h expected AB", rd_data); end
    do_cycle(8'h26, 1'b1, 8'h80, 1'b0);
  endtask

  task automatic test_readback();
    logic [7:0] holes [6];
    holes = '{8'h15, 8'h2A, 8'h1F, 8'h05, 8'h4F, 8'h27};
    ch_active = 4'b0101;
    do_cycle(8'h26, 1'b0, 8'h00, 1'b1);
    checks++;
    if (rd_data !== 8'hF5) begin errors++; $display("FAIL nr52_read got %h expected F5", rd_data); end
    foreach (holes[i]) begin
      do_cycle(holes[i], 1'b1, 8'h00, 1'b1);
      checks++;
      if (rd_data !== 8'hFF || rd_valid !== 1'b1) begin
        errors++; $display("FAIL unmapped_%h got %h/%b expected FF/1", holes[i], rd_data, rd_valid);
      end
    end
  endtask

  task automatic test_same_cycle();
    do_cycle(8'h11, 1'b1, 8'h80, 1'b0);
    do_cycle(8'h11, 1'b1, 8'h40, 1'b1);
    checks++;
    if (rd_data !== 8'hBF || nr1x[15:8] !== 8'h40) begin
      errors++; $display("FAIL same_cycle rd=%h nr11=%h expected BF/40", rd_data, nr1x[15:8]);
    end
    do_cycle(8'h11, 1'b0, 8'h00, 1'b1);
    checks++;
    if (rd_data !== 8'h7F) begin errors++; $display("FAIL after_write got %h expected 7F", rd_data); end
  endtask

  task automatic test_async_reset();
    do_cycle(8'h14, 1'b1, 8'h80, 1'b1);
    checks++;
    if (trig !== 4'b0001 || rd_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset trig=%b v=%b expected 0001/1", trig, rd_valid);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (trig !== 4'h0 || rd_valid !== 1'b0 || rd_data !== 8'h00 || apu_on !== 1'b0 ||
        nr1x !== 40'h0 || wave_table !== INIT) begin
      errors++; $display("FAIL async_reset trig=%b v=%b rd=%h on=%b nr1x=%h expected all cleared",
                         trig, rd_valid, rd_data, apu_on, nr1x);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [7:0] a, d;
    logic we, re;
    do_cycle(8'h26, 1'b1, 8'h80, 1'b0);
    for (int n = 0; n < 400; n++) begin
      ch_active = 4'($urandom);
      d  = 8'($urandom);
      we = 1'($urandom);
      re = 1'($urandom);
      if ($urandom_range(0, 9) == 0) begin
        a = 8'h26;
        if ($urandom_range(0, 5) != 0) d[7] = 1'b1;
      end else begin
        a = 8'($urandom_range(8'h0C, 8'h42));
      end
      do_cycle(a, we, d, re);
      checks++;
      if (nr1x !== {m_reg[8'h14], m_reg[8'h13], m_reg[8'h12], m_reg[8'h11], m_reg[8'h10]} ||
          nr2x !== {m_reg[8'h19], m_reg[8'h18], m_reg[8'h17], m_reg[8'h16]} ||
          nr3x !== {m_reg[8'h1E], m_reg[8'h1D], m_reg[8'h1C], m_reg[8'h1B], m_reg[8'h1A]} ||
          nr4x !== {m_reg[8'h23], m_reg[8'h22], m_reg[8'h21], m_reg[8'h20]} ||
          nr5x !== {m_reg[8'h25], m_reg[8'h24]} || apu_on !== m_on) begin
        errors++; $display("FAIL rand_regs n=%0d a=%h nr1x=%h nr2x=%h nr3x=%h nr4x=%h nr5x=%h on=%b",
                           n, a, nr1x, nr2x, nr3x, nr4x, nr5x, apu_on);
      end
      checks++;
      if (trig !== exp_trig || len_load !== exp_len) begin
        errors++; $display("FAIL rand_strobes n=%0d a=%h trig=%b len=%b expected %b/%b",
                           n, a, trig, len_load, exp_trig, exp_len);
      end
      checks++;
      if (rd_data !== exp_rd_data || rd_valid !== exp_rd_valid) begin
        errors++; $display("FAIL rand_read n=%0d a=%h got %h/%b expected %h/%b",
                           n, a, rd_data, rd_valid, exp_rd_data, exp_rd_valid);
      end
      checks++;
      if (wave_table !== m_wave_img()) begin
        errors++; $display("FAIL rand_wave n=%0d got %h expected %h", n, wave_table, m_wave_img());
      end
    end
  endtask

  initial begin
    test_reset();
    test_trigger();
    test_len_load();
    test_power_off();
    test_readback();
    test_same_cycle();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
